node_fanin_arbiter: RTL and testbench

- Upward fan-in point for one hierarchy node with up to 15 child instances.
- Collects valid/ready packet streams from the child instances and merges them into a single upstream stream to the parent node, tagging each beat with its source child index.
- Arbitration is round-robin at packet granularity: a multi-beat packet is never interleaved with another child's beats.
- Provides a registered output stage and a packet counter for hierarchy-level status.

---
 rtl/node_pkg.sv | 28 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/node_fanin_arbiter.sv | 150 +++++++++++++++
 tb/tb_node_fanin_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : node_pkg                                                        |
// | Purpose  : Shared types, default sizes and helpers for the hierarchy-node  |
// |            fan-in arbiter and its round-robin picker.                      |
// | Contents : fanin_state_e  - arbiter FSM state (IDLE / LOCKED)              |
// |            c_N_CHILD      - default number of child ports                  |
// |            c_DATA_W       - default payload width                          |
// |            next_idx()     - wrap-around increment modulo n                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package node_pkg;

  localparam int c_N_CHILD = 15;
  localparam int c_DATA_W  = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fanin_state_e;

  // Increment idx, returning to 0 once it would reach n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_pick                                                         |
// | Purpose  : Combinational round-robin first-one finder. Scans req starting  |
// |            at ptr, wrapping N_CHILD-1 -> 0, and reports the first set bit. |
// | Ports    : req       in  [N_CHILD]  request vector                         |
// |            ptr       in  [SRC_W]    scan start index (< N_CHILD)           |
// |            gnt_valid out 1          some request was found                 |
// |            gnt_idx   out [SRC_W]    index of the winning request           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_pick
  import node_pkg::*;
#(
  parameter int N_CHILD = c_N_CHILD,
  parameter int SRC_W   = 4
) (
  input  logic [N_CHILD-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [SRC_W-1:0]   gnt_idx
);

  // One extra bit so ptr + offset never overflows before the wrap subtract.
  logic [SRC_W:0] w_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      w_idx = {1'b0, ptr} + (SRC_W+1)'(k);
      if (w_idx >= (SRC_W+1)'(N_CHILD)) begin
        w_idx = w_idx - (SRC_W+1)'(N_CHILD);
      end
      if (!gnt_valid && req[w_idx[SRC_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx[SRC_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/node_fanin_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : node_fanin_arbiter                                              |
// | Purpose  : Upward fan-in for one hierarchy node. Merges child valid/ready  |
// |            packet streams into one registered upstream stream, tagging     |
// |            each beat with its source child. Round-robin between packets;   |
// |            a packet is never interleaved with another child's beats.       |
// | Ports    : clk, rst_n            clock, async active-low reset             |
// |            child_valid/data/last per-child beat stream inputs              |
// |            child_ready           per-child accept (one-hot or zero)        |
// |            up_valid/data/src/last registered upstream beat                 |
// |            up_ready              parent accept                             |
// |            pkt_count             completed packets sent upstream (wraps)   |
// |            busy                  packet in progress or output occupied     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module node_fanin_arbiter
  import node_pkg::*;
#(
  parameter int N_CHILD = c_N_CHILD,
  parameter int DATA_W  = c_DATA_W,
  parameter int SRC_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CHILD-1:0]        child_valid,
  input  logic [N_CHILD*DATA_W-1:0] child_data,
  input  logic [N_CHILD-1:0]        child_last,
  output logic [N_CHILD-1:0]        child_ready,
  output logic                      up_valid,
  output logic [DATA_W-1:0]         up_data,
  output logic [SRC_W-1:0]          up_src,
  output logic                      up_last,
  input  logic                      up_ready,
  output logic [CNT_W-1:0]          pkt_count,
  output logic                      busy
);

  fanin_state_e      r_state;
  logic [SRC_W-1:0]  r_lock_idx;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic              r_up_valid;
  logic [DATA_W-1:0] r_up_data;
  logic [SRC_W-1:0]  r_up_src;
  logic              r_up_last;
  logic [CNT_W-1:0]  r_pkt_count;

  logic              w_load_en;
  logic              w_gnt_valid;
  logic [SRC_W-1:0]  w_gnt_idx;
  logic              w_sel_active;
  logic [SRC_W-1:0]  w_sel_idx;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;
  logic              w_xfer;

  // Output register can take a beat when empty or draining this cycle.
  assign w_load_en = !r_up_valid || up_ready;

  rr_pick #(
    .N_CHILD (N_CHILD),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req       (child_valid),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // While a packet is open only its owner may be served; other children's
  // valid is ignored until the last beat passes.
  always_comb begin
    w_sel_active = (r_state == LOCKED) ? 1'b1 : w_gnt_valid;
    w_sel_idx    = (r_state == LOCKED) ? r_lock_idx : w_gnt_idx;
    w_sel_data   = '0;
    for (int i = 0; i < N_CHILD; i++) begin
      if (w_sel_idx == SRC_W'(i)) begin
        w_sel_data = child_data[i*DATA_W +: DATA_W];
      end
    end
    w_sel_last = child_last[w_sel_idx];
  end

  // rst_n gates ready so no child sees an accept while the block is held in reset.
  always_comb begin
    child_ready = '0;
    if (rst_n && w_sel_active && w_load_en) begin
      child_ready[w_sel_idx] = 1'b1;
    end
  end

  assign w_xfer = rst_n && w_sel_active && w_load_en && child_valid[w_sel_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lock_idx  <= '0;
      r_rr_ptr    <= '0;
      r_up_valid  <= 1'b0;
      r_up_data   <= '0;
      r_up_src    <= '0;
      r_up_last   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      if (r_up_valid && up_ready && r_up_last) begin
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end

      // Payload fields hold when the register empties without a new beat.
      if (w_load_en) begin
        r_up_valid <= w_xfer;
        if (w_xfer) begin
          r_up_data <= w_sel_data;
          r_up_src  <= w_sel_idx;
          r_up_last <= w_sel_last;
        end
      end

      if (w_xfer) begin
        case (r_state)
          IDLE: begin
            if (w_sel_last) begin
              r_rr_ptr <= SRC_W'(next_idx(32'(w_gnt_idx), N_CHILD));
            end else begin
              r_state    <= LOCKED;
              r_lock_idx <= w_gnt_idx;
            end
          end
          LOCKED: begin
            if (w_sel_last) begin
              r_state  <= IDLE;
              r_rr_ptr <= SRC_W'(next_idx(32'(r_lock_idx), N_CHILD));
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign up_valid  = r_up_valid;
  assign up_data   = r_up_data;
  assign up_src    = r_up_src;
  assign up_last   = r_up_last;
  assign pkt_count = r_pkt_count;
  assign busy      = (r_state == LOCKED) || r_up_valid;

endmodule
`default_nettype wire

// File: tb/tb_node_fanin_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_node_fanin_arbiter                                           |
// | Purpose  : Self-checking bench for node_fanin_arbiter. Per-child beat      |
// |            queues drive the inputs; a packet-level reference model checks |
// |            every cycle; directed scenarios pin literal expectations.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_node_fanin_arbiter;

  localparam int N  = 15;
  localparam int DW = 16;
  localparam int SW = 4;
  localparam int CW = 16;
  localparam int QD = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    child_valid = '0;
  logic [N*DW-1:0] child_data = '0;
  logic [N-1:0]    child_last = '0;
  logic [N-1:0]    child_ready;
  logic            up_valid;
  logic [DW-1:0]   up_data;
  logic [SW-1:0]   up_src;
  logic            up_last;
  logic            up_ready = 1'b1;
  logic [CW-1:0]   pkt_count;
  logic            busy;

  always #5 clk = ~clk;

  node_fanin_arbiter #(.N_CHILD(N), .DATA_W(DW), .SRC_W(SW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_last  (child_last),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_src      (up_src),
    .up_last     (up_last),
    .up_ready    (up_ready),
    .pkt_count   (pkt_count),
    .busy        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- child sources: one FIFO of {last,data} per child ----------
  logic [DW:0] rbuf [N][QD];
  int head [N];
  int tail [N];
  int auto_left [N];
  logic [N-1:0] hs = '0;
  int pushed = 0;

  task automatic push(input int ch, input logic [DW-1:0] d, input logic l);
    rbuf[ch][tail[ch] % QD] = {l, d};
    tail[ch]++;
    pushed++;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      head[i] = tail[i];
      auto_left[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; auto_left[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) head[i]++;
        if (auto_left[i] > 0 && (tail[i] - head[i]) < 4) begin
          push(i, DW'(auto_left[i]), 1'b1);
          auto_left[i]--;
        end
        if (head[i] != tail[i]) begin
          child_valid[i] = 1'b1;
          child_data[i*DW +: DW] = rbuf[i][head[i] % QD][DW-1:0];
          child_last[i] = rbuf[i][head[i] % QD][DW];
        end else begin
          child_valid[i] = 1'b0;
          child_data[i*DW +: DW] = '0;
          child_last[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------------
  int m_owner = -1;           // child holding an open packet, -1 if none
  int m_ptr = 0;              // next child to be favoured
  int m_cnt = 0;
  logic m_ov = 1'b0;
  logic [DW-1:0] m_od = '0;
  int m_os = 0;
  logic m_ol = 1'b0;

  int cyc = 0;
  int n_up_hs = 0;
  bit log_en = 1'b1;
  int log_src[$];
  logic [DW-1:0] log_data[$];
  logic log_last[$];
  int log_cyc[$];

  logic [N-1:0] prev_valid = '0;
  logic [N-1:0] prev_hs = '0;
  logic prev_rst = 1'b0;

  initial begin : compare_proc
    int sel;
    logic load;
    logic xfer;
    logic [N-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; m_cnt = 0;
        m_ov = 1'b0; m_od = '0; m_os = 0; m_ol = 1'b0;
        check("rst_child_ready", 64'(child_ready), 64'd0);
        check("rst_up_valid", 64'(up_valid), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        hs = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          assert (!(prev_rst && prev_valid[i] && !prev_hs[i] && !child_valid[i]))
          else begin
            n_bad++;
            $error("FAIL valid_drop: child %0d dropped valid before handshake", i);
          end
        end
        check("up_valid", 64'(up_valid), 64'(m_ov));
        check("up_data", 64'(up_data), 64'(m_od));
        check("up_src", 64'(up_src), 64'(m_os));
        check("up_last", 64'(up_last), 64'(m_ol));
        check("pkt_count", 64'(pkt_count), 64'(m_cnt));
        check("busy", 64'(busy), 64'((m_owner >= 0) || m_ov));

        load = !m_ov || up_ready;
        sel = -1;
        if (m_owner >= 0) sel = m_owner;
        else begin
          for (int k = 0; k < N; k++) begin
            if (sel < 0 && child_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
          end
        end
        exp_rdy = '0;
        if (sel >= 0 && load) exp_rdy[sel] = 1'b1;
        check("child_ready", 64'(child_ready), 64'(exp_rdy));
        hs = child_valid & child_ready;

        if (up_valid && up_ready) begin
          n_up_hs++;
          if (log_en) begin
            log_src.push_back(int'(up_src));
            log_data.push_back(up_data);
            log_last.push_back(up_last);
            log_cyc.push_back(cyc);
          end
        end
        if (m_ov && up_ready && m_ol) m_cnt = (m_cnt + 1) % 65536;
        xfer = (sel >= 0) && load && child_valid[sel];
        if (load) m_ov = xfer;
        if (xfer) begin
          m_od = DW'(child_data >> (sel * DW));
          m_os = sel;
          m_ol = child_last[sel];
          if (child_last[sel]) begin
            m_owner = -1;
            m_ptr = (sel + 1) % N;
          end else begin
            m_owner = sel;
          end
        end
      end
      prev_valid = child_valid;
      prev_hs = hs;
      prev_rst = rst_n;
    end
  end

  // ---------------- directed / random scenarios ------------------------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_log();
    log_src.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    up_ready = 1'b1;
    steps(2);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic expect_beat(input string name, input int k, input int src,
                             input logic [DW-1:0] d, input logic l);
    if (log_src.size() > k) begin
      check({name, "_src"}, 64'(log_src[k]), 64'(src));
      check({name, "_data"}, 64'(log_data[k]), 64'(d));
      check({name, "_last"}, 64'(log_last[k]), 64'(l));
    end else begin
      check({name, "_present"}, 64'(log_src.size()), 64'(k + 1));
    end
  endtask

  initial begin : main
    bit done;
    int ch;
    int len;

    // Reset with every child requesting.
    for (int i = 0; i < N; i++) push(i, DW'(16'hC000 + i), 1'b1);
    steps(3);
    check("reset_ready_all_valid", 64'(child_ready), 64'd0);
    check("reset_up_valid", 64'(up_valid), 64'd0);
    check("reset_pkt_count", 64'(pkt_count), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    clear_log();
    rst_n = 1'b1;
    steps(20);
    check("reset_drain_count", 64'(log_src.size()), 64'd15);
    for (int k = 0; k < N; k++) expect_beat("reset_order", k, k, DW'(16'hC000 + k), 1'b1);
    check("reset_pkt_total", 64'(pkt_count), 64'd15);

    // Round-robin among children 2, 5, 14.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push(2, DW'(16'h0200 + r), 1'b1);
      push(5, DW'(16'h0500 + r), 1'b1);
      push(14, DW'(16'h0E00 + r), 1'b1);
    end
    steps(12);
    check("rr_count", 64'(log_src.size()), 64'd6);
    expect_beat("rr0", 0, 2, 16'h0200, 1'b1);
    expect_beat("rr1", 1, 5, 16'h0500, 1'b1);
    expect_beat("rr2", 2, 14, 16'h0E00, 1'b1);
    expect_beat("rr3", 3, 2, 16'h0201, 1'b1);
    expect_beat("rr4", 4, 5, 16'h0501, 1'b1);
    expect_beat("rr5", 5, 14, 16'h0E01, 1'b1);
    if (log_cyc.size() == 6) check("rr_back_to_back", 64'(log_cyc[5] - log_cyc[0]), 64'd5);
    check("rr_pkt_count", 64'(pkt_count), 64'd6);

    // Packet lock: child 3 four-beat packet, child 4 waiting.
    do_reset();
    for (int b = 0; b < 4; b++) push(3, DW'(16'h0A00 + b), b == 3);
    push(4, 16'h0B00, 1'b1);
    steps(10);
    expect_beat("lock0", 0, 3, 16'h0A00, 1'b0);
    expect_beat("lock1", 1, 3, 16'h0A01, 1'b0);
    expect_beat("lock2", 2, 3, 16'h0A02, 1'b0);
    expect_beat("lock3", 3, 3, 16'h0A03, 1'b1);
    expect_beat("lock4", 4, 4, 16'h0B00, 1'b1);
    if (log_cyc.size() == 5) check("lock_back_to_back", 64'(log_cyc[4] - log_cyc[0]), 64'd4);

    // Back-pressure.
    do_reset();
    up_ready = 1'b0;
    push(6, 16'h1234, 1'b1);
    push(8, 16'h5678, 1'b1);
    steps(2);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(up_valid), 64'd1);
      check("bp_data", 64'(up_data), 64'h1234);
      check("bp_src", 64'(up_src), 64'd6);
      check("bp_ready_zero", 64'(child_ready), 64'd0);
      step();
    end
    up_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(child_ready), 64'h0100);
    step();
    check("bp_next_valid", 64'(up_valid), 64'd1);
    check("bp_next_data", 64'(up_data), 64'h5678);
    check("bp_next_src", 64'(up_src), 64'd8);
    expect_beat("bp_drained", 0, 6, 16'h1234, 1'b1);

    // Pointer wrap 14 -> 0 -> 1.
    do_reset();
    push(13, 16'h0D13, 1'b1);
    steps(4);
    push(0, 16'h0D00, 1'b1);
    steps(4);
    push(0, 16'h0E00, 1'b1);
    push(1, 16'h0E01, 1'b1);
    steps(6);
    expect_beat("wrap0", 0, 13, 16'h0D13, 1'b1);
    expect_beat("wrap1", 1, 0, 16'h0D00, 1'b1);
    expect_beat("wrap2", 2, 1, 16'h0E01, 1'b1);
    expect_beat("wrap3", 3, 0, 16'h0E00, 1'b1);

    // Reset in the middle of child 7's packet.
    do_reset();
    for (int b = 0; b < 4; b++) push(7, DW'(16'h7700 + b), b == 3);
    for (int k = 0; k < 30 && log_src.size() < 2; k++) step();
    check("mid_two_beats", 64'(log_src.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check("mid_clr_valid", 64'(up_valid), 64'd0);
    check("mid_clr_data", 64'(up_data), 64'd0);
    check("mid_clr_src", 64'(up_src), 64'd0);
    check("mid_clr_last", 64'(up_last), 64'd0);
    check("mid_clr_busy", 64'(busy), 64'd0);
    check("mid_clr_ready", 64'(child_ready), 64'd0);
    push(1, 16'h1100, 1'b1);
    steps(2);
    rst_n = 1'b1;
    clear_log();
    steps(6);
    expect_beat("mid_first", 0, 1, 16'h1100, 1'b1);
    expect_beat("mid_second", 1, 7, 16'h7703, 1'b1);

    // Randomized traffic with random back-pressure.
    do_reset();
    pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      up_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, N - 1);
        len = $urandom_range(1, 4);
        if (tail[ch] - head[ch] < QD - 8) begin
          for (int b = 0; b < len; b++) push(ch, DW'($urandom), b == len - 1);
        end
      end
      step();
    end
    up_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      done = !up_valid && !busy;
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 1'b0;
      if (!done) step();
    end
    check("rand_drained", 64'(done), 64'd1);
    check("rand_beat_total", 64'(log_src.size()), 64'(pushed));

    // Completed-packet counter wrap.
    do_reset();
    log_en = 1'b0;
    n_up_hs = 0;
    auto_left[0] = 65536;
    for (int k = 0; k < 70000 && n_up_hs < 65535; k++) step();
    check("cnt_reach_ffff", 64'(n_up_hs), 64'd65535);
    check("cnt_ffff", 64'(pkt_count), 64'hFFFF);
    for (int k = 0; k < 10 && n_up_hs < 65536; k++) step();
    check("cnt_wrap_zero", 64'(pkt_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
